ahb_print_master: RTL

AHB-Lite master that turns a byte-stream debug message into the monitor's print protocol. It writes a header word, then the packed message bytes, then a terminator word to the monitor's mailbox registers. It also issues single-word test-start commands to the monitor's command register. The block sits directly upstream of the AHB monitor on the test AHB segment and is its only writer there.

---
 rtl/ahb_print_pkg.sv | 35 +++
 rtl/ahb_print_buf.sv | 56 +++++
 rtl/ahb_print_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_print_pkg.sv
// ============================================================================
// Module   : ahb_print_pkg
// Brief    : Shared AHB encodings, print-protocol words and FSM state codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_print_pkg;

    localparam logic [1:0]  c_htrans_idle   = 2'b00;
    localparam logic [1:0]  c_htrans_nonseq = 2'b10;
    localparam logic [2:0]  c_hsize_byte    = 3'b000;
    localparam logic [2:0]  c_hsize_word    = 3'b010;
    localparam logic [2:0]  c_hburst_single = 3'b000;
    localparam logic [3:0]  c_hprot_data    = 4'b0011;

    localparam logic [23:0] c_hdr_magic = 24'hdddd11;
    localparam logic [31:0] c_term_word = 32'hdddd_eeee;

    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_collect = 3'd1;
    localparam logic [2:0]  c_st_hdr     = 3'd2;
    localparam logic [2:0]  c_st_data    = 3'd3;
    localparam logic [2:0]  c_st_tail    = 3'd4;
    localparam logic [2:0]  c_st_term    = 3'd5;
    localparam logic [2:0]  c_st_cmd     = 3'd6;

    localparam logic [2:0]  c_cmd_jtag  = 3'd1;
    localparam logic [2:0]  c_cmd_qspi0 = 3'd2;
    localparam logic [2:0]  c_cmd_qspi1 = 3'd3;
    localparam logic [2:0]  c_cmd_i2c   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ahb_print_buf.sv
// ============================================================================
// Module   : ahb_print_buf
// Brief    : Message byte buffer with write count and a 4-byte read window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_print_buf #(
    parameter int unsigned MAX_LEN = 100,
    localparam int unsigned c_cw   = $clog2(MAX_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_wr_en,
    input  logic [7:0]      i_wr_data,
    input  logic [c_cw-1:0] i_rd_idx,
    output logic [c_cw-1:0] o_count,
    output logic            o_full,
    output logic [31:0]     o_rd_word
);

    localparam int unsigned      c_aw  = $clog2(MAX_LEN);
    localparam logic [c_cw:0]    c_max = (c_cw + 1)'(MAX_LEN);
    localparam logic [c_cw-1:0]  c_cap = c_cw'(MAX_LEN);

    logic [7:0]      r_mem [MAX_LEN];
    logic [c_cw-1:0] r_count;

    assign o_count = r_count;
    assign o_full  = (r_count == c_cap);

    // Bytes written once the buffer is full are silently dropped here.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_wr_en && !o_full) begin
            r_count <= r_count + c_cw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en && !o_full) begin
            r_mem[r_count[c_aw-1:0]] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [c_cw:0] w_idx;
        assign w_idx = {1'b0, i_rd_idx} + (c_cw + 1)'(k);
        assign o_rd_word[31-8*k -: 8] = (w_idx < c_max) ? r_mem[w_idx[c_aw-1:0]] : 8'h00;
    end

endmodule

`default_nettype wire

// File: rtl/ahb_print_master.sv
// ============================================================================
// Module   : ahb_print_master
// Brief    : AHB-Lite master writing debug messages and test-start commands
//            to the monitor's mailbox and command registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_print_master
    import ahb_print_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0008_0000,
    parameter logic [31:0] CMD_ADDR  = 32'h0009_0008,
    parameter int unsigned MAX_LEN   = 100
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [7:0]  msg_data,
    input  logic        msg_last,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_id,
    output logic        hsel,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    output logic        busy,
    output logic        err,
    output logic        trunc
);

    localparam int unsigned        c_cw       = $clog2(MAX_LEN + 1);
    localparam logic [c_cw-3:0]    c_one_word = (c_cw - 2)'(1);

    logic [2:0]      r_state;
    logic            r_msg_ready;
    logic            r_cmd_ready;
    logic            r_hsel;
    logic [31:0]     r_haddr;
    logic [1:0]      r_htrans;
    logic            r_hwrite;
    logic [2:0]      r_hsize;
    logic [31:0]     r_hwdata;
    logic            r_busy;
    logic            r_err;
    logic            r_trunc;
    logic            r_dphase;
    logic [2:0]      r_cmd_id;
    logic [c_cw-1:0] r_idx;
    logic [c_cw-3:0] r_words_left;
    logic [1:0]      r_tail_left;

    logic [c_cw-1:0] w_count;
    logic            w_full;
    logic [31:0]     w_rd_word;
    logic            w_in_idle;
    logic            w_msg_take;
    logic            w_accept;
    logic            w_abort;
    logic            w_dphase_done;
    logic            w_term_done;
    logic            w_buf_clr;

    assign w_in_idle     = (r_state == c_st_idle);
    // A pending command wins in IDLE, so the byte must not be handshaken then.
    assign msg_ready     = r_msg_ready & ~(w_in_idle & cmd_valid);
    assign cmd_ready     = r_cmd_ready;
    assign w_msg_take    = msg_valid & msg_ready & (w_in_idle | (r_state == c_st_collect));
    assign w_accept      = hready & (r_htrans == c_htrans_nonseq);
    assign w_abort       = r_dphase & hresp;
    assign w_dphase_done = r_dphase & hready;
    assign w_term_done   = (r_state == c_st_term) & (r_htrans == c_htrans_idle) & w_dphase_done;
    assign w_buf_clr     = w_abort | w_term_done;

    assign hsel   = r_hsel;
    assign haddr  = r_haddr;
    assign htrans = r_htrans;
    assign hwrite = r_hwrite;
    assign hsize  = r_hsize;
    assign hburst = c_hburst_single;
    assign hprot  = c_hprot_data;
    assign hwdata = r_hwdata;
    assign busy   = r_busy;
    assign err    = r_err;
    assign trunc  = r_trunc;

    ahb_print_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk       (hclk),
        .rst       (hreset),
        .i_clr     (w_buf_clr),
        .i_wr_en   (w_msg_take),
        .i_wr_data (msg_data),
        .i_rd_idx  (r_idx),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_rd_word (w_rd_word)
    );

    // r_state names the transfer whose address phase is on the bus; each
    // accepted address phase loads hwdata for the data phase that follows.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state      <= c_st_idle;
            r_msg_ready  <= 1'b1;
            r_cmd_ready  <= 1'b1;
            r_hsel       <= 1'b0;
            r_haddr      <= '0;
            r_htrans     <= c_htrans_idle;
            r_hwrite     <= 1'b0;
            r_hsize      <= c_hsize_word;
            r_hwdata     <= '0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_trunc      <= 1'b0;
            r_dphase     <= 1'b0;
            r_cmd_id     <= '0;
            r_idx        <= '0;
            r_words_left <= '0;
            r_tail_left  <= '0;
        end else if (w_abort) begin
            r_err       <= 1'b1;
            r_trunc     <= 1'b0;
            r_state     <= c_st_idle;
            r_msg_ready <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_hsel      <= 1'b0;
            r_htrans    <= c_htrans_idle;
            r_hwrite    <= 1'b0;
            r_busy      <= 1'b0;
            r_dphase    <= 1'b0;
        end else begin
            r_trunc <= 1'b0;
            if (hready) begin
                r_dphase <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_cmd_id    <= cmd_id;
                        r_state     <= c_st_cmd;
                        r_msg_ready <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_hsel      <= 1'b1;
                        r_htrans    <= c_htrans_nonseq;
                        r_hwrite    <= 1'b1;
                        r_haddr     <= CMD_ADDR;
                        r_hsize     <= c_hsize_word;
                    end else if (msg_valid) begin
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        if (msg_last) begin
                            r_state     <= c_st_hdr;
                            r_msg_ready <= 1'b0;
                            r_hsel      <= 1'b1;
                            r_htrans    <= c_htrans_nonseq;
                            r_hwrite    <= 1'b1;
                            r_haddr     <= BASE_ADDR;
                            r_hsize     <= c_hsize_word;
                        end else begin
                            r_state <= c_st_collect;
                        end
                    end
                end
                c_st_collect: begin
                    if (msg_valid) begin
                        r_trunc <= w_full;
                        if (msg_last) begin
                            r_state     <= c_st_hdr;
                            r_msg_ready <= 1'b0;
                            r_hsel      <= 1'b1;
                            r_htrans    <= c_htrans_nonseq;
                            r_hwrite    <= 1'b1;
                            r_haddr     <= BASE_ADDR;
                            r_hsize     <= c_hsize_word;
                        end
                    end
                end
                c_st_hdr: begin
                    if (w_accept) begin
                        r_hwdata <= {c_hdr_magic, 8'(w_count)};
                        r_dphase <= 1'b1;
                        r_idx    <= '0;
                        r_haddr  <= BASE_ADDR + 32'd4;
                        if (w_count[c_cw-1:2] != '0) begin
                            r_state      <= c_st_data;
                            r_words_left <= w_count[c_cw-1:2];
                            r_hsize      <= c_hsize_word;
                        end else begin
                            r_state     <= c_st_tail;
                            r_tail_left <= w_count[1:0];
                            r_hsize     <= c_hsize_byte;
                        end
                    end
                end
                c_st_data: begin
                    if (w_accept) begin
                        r_hwdata     <= w_rd_word;
                        r_dphase     <= 1'b1;
                        r_idx        <= r_idx + c_cw'(4);
                        r_words_left <= r_words_left - c_one_word;
                        if (r_words_left == c_one_word) begin
                            if (w_count[1:0] != 2'd0) begin
                                r_state     <= c_st_tail;
                                r_tail_left <= w_count[1:0];
                                r_hsize     <= c_hsize_byte;
                            end else begin
                                r_state <= c_st_term;
                                r_haddr <= BASE_ADDR;
                            end
                        end
                    end
                end
                c_st_tail: begin
                    if (w_accept) begin
                        r_hwdata    <= {4{w_rd_word[31:24]}};
                        r_dphase    <= 1'b1;
                        r_idx       <= r_idx + c_cw'(1);
                        r_tail_left <= r_tail_left - 2'd1;
                        if (r_tail_left == 2'd1) begin
                            r_state <= c_st_term;
                            r_haddr <= BASE_ADDR;
                            r_hsize <= c_hsize_word;
                        end
                    end
                end
                c_st_term, c_st_cmd: begin
                    if (w_accept) begin
                        r_hwdata <= (r_state == c_st_term) ? c_term_word : {29'b0, r_cmd_id};
                        r_dphase <= 1'b1;
                        r_hsel   <= 1'b0;
                        r_htrans <= c_htrans_idle;
                        r_hwrite <= 1'b0;
                    end else if ((r_htrans == c_htrans_idle) && w_dphase_done) begin
                        r_state     <= c_st_idle;
                        r_msg_ready <= 1'b1;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
